reg_bank_8: RTL and testbench

//  8-entry register bank; directly downstream of the 3-to-8 write-select decoder.
//  - Consumes the decoder's one-hot write strobes; provides two registered read ports.
//  - Sits in the processor's register-file / write-back path.
//  - Rejects malformed (multi-hot) strobes and reports them.

---
 rtl/reg_bank_pkg.sv | 23 ++
 rtl/onehot_chk8.sv | 31 +++
 rtl/reg_bank_8.sv | 124 ++++++++++++
 tb/tb_reg_bank_8.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : reg_bank_pkg                                                     |
// | Shared sizing constants and helpers for the 8-entry register bank.         |
// |   NUM_REGS  : number of entries (one per write strobe bit)                 |
// |   IDX_W     : read index width                                             |
// |   ERR_CNT_W : width of the saturating multi-hot error counter              |
// |   is_onehot8: returns 1 when exactly one bit of an 8-bit vector is set     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package reg_bank_pkg;

  localparam int NUM_REGS  = 8;
  localparam int IDX_W     = 3;
  localparam int ERR_CNT_W = 8;

  // Clearing the lowest set bit leaves zero only for a single-bit value.
  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_chk8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : onehot_chk8                                                      |
// | Combinational classifier for the 8-bit write-strobe vector.                |
// | Ports:                                                                     |
// |   wr_sel_i    in  8  write strobes from the write-select decoder           |
// |   is_onehot_o out 1  exactly one strobe set                                |
// |   is_zero_o   out 1  no strobe set                                         |
// |   is_multi_o  out 1  two or more strobes set (malformed)                   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module onehot_chk8
  import reg_bank_pkg::*;
(
  input  logic [NUM_REGS-1:0] wr_sel_i,
  output logic                is_onehot_o,
  output logic                is_zero_o,
  output logic                is_multi_o
);

  logic w_onehot;
  logic w_zero;

  assign w_onehot    = is_onehot8(wr_sel_i);
  assign w_zero      = (wr_sel_i == '0);
  assign is_onehot_o = w_onehot;
  assign is_zero_o   = w_zero;
  assign is_multi_o  = ~w_onehot & ~w_zero;

endmodule
`default_nettype wire

// File: rtl/reg_bank_8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : reg_bank_8                                                       |
// | 8-entry register bank fed by one-hot write strobes, with two registered    |
// | read ports and rejection/counting of malformed multi-hot strobes.          |
// | Parameters:                                                                |
// |   WIDTH    : entry data width                                              |
// |   ZERO_REG : 1 -> entry 0 reads as zero and ignores writes                 |
// | Build option: define REG_BANK_BYPASS_EN to forward same-cycle write data   |
// |   to a read of the same entry; otherwise such a read sees the old value.   |
// | Ports:                                                                     |
// |   clock_i     in  1      clock, rising edge                                |
// |   reset_i     in  1      synchronous active-high reset                     |
// |   wr_sel_i    in  8      one-hot write strobes (0 = no write)              |
// |   wr_data_i   in  WIDTH  write data                                        |
// |   rd_en_i     in  1      read request                                      |
// |   rd_addr_a_i in  3      read index, port A                                |
// |   rd_addr_b_i in  3      read index, port B                                |
// |   rd_data_a_o out WIDTH  registered read data, port A                      |
// |   rd_data_b_o out WIDTH  registered read data, port B                      |
// |   rd_valid_o  out 1      high the cycle after an accepted read             |
// |   sel_err_o   out 1      one-cycle pulse after a multi-hot strobe          |
// |   err_cnt_o   out 8      saturating multi-hot strobe count                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module reg_bank_8
  import reg_bank_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [NUM_REGS-1:0]  wr_sel_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic                 rd_en_i,
  input  logic [IDX_W-1:0]     rd_addr_a_i,
  input  logic [IDX_W-1:0]     rd_addr_b_i,
  output logic [WIDTH-1:0]     rd_data_a_o,
  output logic [WIDTH-1:0]     rd_data_b_o,
  output logic                 rd_valid_o,
  output logic                 sel_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [ERR_CNT_W-1:0] c_ERR_MAX = {ERR_CNT_W{1'b1}};

  logic [WIDTH-1:0]     entry_q [NUM_REGS];
  logic [WIDTH-1:0]     rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0]     rd_data_b_q, rd_data_b_d;
  logic                 rd_valid_q;
  logic                 sel_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic                 w_is_onehot;
  logic                 w_is_zero;
  logic                 w_is_multi;
  logic                 w_wr_ok;
  logic [NUM_REGS-1:0]  w_we;

  onehot_chk8 u_chk (
    .wr_sel_i    (wr_sel_i),
    .is_onehot_o (w_is_onehot),
    .is_zero_o   (w_is_zero),
    .is_multi_o  (w_is_multi)
  );

  assign w_wr_ok = w_is_onehot & ~w_is_zero;

  // Per-entry write enables. Entry 0 is hard-wired read-only when it is the
  // zero register, so a lone strobe to it is silently dropped (not an error).
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_we
    if (gi == 0 && ZERO_REG) begin : g_zero
      assign w_we[gi] = 1'b0;
    end else begin : g_norm
      assign w_we[gi] = w_wr_ok & wr_sel_i[gi];
    end
  end

  // Read muxes. Forwarding keys off the gated enables, so it never applies to
  // a rejected multi-hot write or to the zero register.
  always_comb begin
    rd_data_a_d = entry_q[rd_addr_a_i];
    rd_data_b_d = entry_q[rd_addr_b_i];
`ifdef REG_BANK_BYPASS_EN
    if (w_we[rd_addr_a_i]) rd_data_a_d = wr_data_i;
    if (w_we[rd_addr_b_i]) rd_data_b_d = wr_data_i;
`endif
    if (ZERO_REG && (rd_addr_a_i == '0)) rd_data_a_d = '0;
    if (ZERO_REG && (rd_addr_b_i == '0)) rd_data_b_d = '0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) entry_q[i] <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_valid_q  <= 1'b0;
      sel_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_we[i]) entry_q[i] <= wr_data_i;
      end
      if (rd_en_i) begin
        rd_data_a_q <= rd_data_a_d;
        rd_data_b_q <= rd_data_b_d;
      end
      rd_valid_q <= rd_en_i;
      sel_err_q  <= w_is_multi;
      if (w_is_multi && (err_cnt_q != c_ERR_MAX)) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign rd_data_a_o = rd_data_a_q;
  assign rd_data_b_o = rd_data_b_q;
  assign rd_valid_o  = rd_valid_q;
  assign sel_err_o   = sel_err_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_8.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_reg_bank_8                                                    |
// | Self-checking bench for reg_bank_8 (WIDTH=32, ZERO_REG=1): a directed      |
// | vector table plus hand sequences for counter saturation and streaming      |
// | back-to-back reads. Honours REG_BANK_BYPASS_EN for forwarding results.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_reg_bank_8;

`ifdef REG_BANK_BYPASS_EN
  localparam bit c_BYP = 1'b1;
`else
  localparam bit c_BYP = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [7:0]  wr_sel;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid, sel_err;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  reg_bank_8 #(.WIDTH(32), .ZERO_REG(1'b1)) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .wr_sel_i    (wr_sel),
    .wr_data_i   (wr_data),
    .rd_en_i     (rd_en),
    .rd_addr_a_i (rd_addr_a),
    .rd_addr_b_i (rd_addr_b),
    .rd_data_a_o (rd_data_a),
    .rd_data_b_o (rd_data_b),
    .rd_valid_o  (rd_valid),
    .sel_err_o   (sel_err),
    .err_cnt_o   (err_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [7:0]  sel;
    logic [31:0] wd;
    logic        re;
    logic [2:0]  a;
    logic [2:0]  b;
    logic        ev;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        ee;
    logic [7:0]  ec;
  } vec_t;

  localparam int c_NVEC = 18;
  vec_t vecs [c_NVEC];

  function automatic vec_t mk(logic rst, logic [7:0] sel, logic [31:0] wd,
                              logic re, logic [2:0] a, logic [2:0] b,
                              logic ev, logic [31:0] ea, logic [31:0] eb,
                              logic ee, logic [7:0] ec);
    vec_t v;
    v.rst = rst; v.sel = sel; v.wd = wd; v.re = re; v.a = a; v.b = b;
    v.ev = ev; v.ea = ea; v.eb = eb; v.ee = ee; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive away from the active edge, let one edge pass, sample just after it.
  task automatic step(input logic rst, input logic [7:0] sel, input logic [31:0] wd,
                      input logic re, input logic [2:0] a, input logic [2:0] b);
    @(negedge clock);
    reset = rst; wr_sel = sel; wr_data = wd; rd_en = re; rd_addr_a = a; rd_addr_b = b;
    @(posedge clock);
    #1;
  endtask

  logic [31:0] model [8];
  logic [31:0] byp_a5, byp_e1;

  initial begin
    reset = 1'b1; wr_sel = '0; wr_data = '0; rd_en = 1'b0; rd_addr_a = '0; rd_addr_b = '0;

    byp_a5 = c_BYP ? 32'h0000_A5A5 : 32'h0000_0001;
    byp_e1 = c_BYP ? 32'h0000_0022 : 32'h0000_0000;

    //               rst  sel    wd            re  a  b   ev  ea            eb            ee  ec
    vecs[0]  = mk(1, 8'h00, 32'h0,        0, 0, 0,  0, 32'h0,        32'h0,        0, 8'd0);
    vecs[1]  = mk(0, 8'h00, 32'h0,        1, 3, 5,  1, 32'h0,        32'h0,        0, 8'd0);
    vecs[2]  = mk(0, 8'h08, 32'hDEADBEEF, 0, 0, 0,  0, 32'h0,        32'h0,        0, 8'd0);
    vecs[3]  = mk(0, 8'h00, 32'h0,        1, 3, 0,  1, 32'hDEADBEEF, 32'h0,        0, 8'd0);
    vecs[4]  = mk(0, 8'h01, 32'h1234,     1, 0, 3,  1, 32'h0,        32'hDEADBEEF, 0, 8'd0);
    vecs[5]  = mk(0, 8'h00, 32'h0,        1, 0, 0,  1, 32'h0,        32'h0,        0, 8'd0);
    vecs[6]  = mk(0, 8'h0C, 32'hFFFFFFFF, 1, 2, 3,  1, 32'h0,        32'hDEADBEEF, 1, 8'd1);
    vecs[7]  = mk(0, 8'h00, 32'h0,        1, 2, 3,  1, 32'h0,        32'hDEADBEEF, 0, 8'd1);
    vecs[8]  = mk(0, 8'h20, 32'h1,        0, 0, 0,  0, 32'h0,        32'hDEADBEEF, 0, 8'd1);
    vecs[9]  = mk(0, 8'h20, 32'hA5A5,     1, 5, 5,  1, byp_a5,       byp_a5,       0, 8'd1);
    vecs[10] = mk(0, 8'h00, 32'h0,        1, 5, 3,  1, 32'hA5A5,     32'hDEADBEEF, 0, 8'd1);
    vecs[11] = mk(0, 8'h02, 32'h22,       1, 1, 1,  1, byp_e1,       byp_e1,       0, 8'd1);
    vecs[12] = mk(1, 8'h10, 32'h77,       1, 4, 4,  0, 32'h0,        32'h0,        0, 8'd0);
    vecs[13] = mk(0, 8'h00, 32'h0,        1, 4, 3,  1, 32'h0,        32'h0,        0, 8'd0);
    vecs[14] = mk(0, 8'h00, 32'h55,       1, 7, 6,  1, 32'h0,        32'h0,        0, 8'd0);
    vecs[15] = mk(0, 8'hFF, 32'h9,        0, 0, 0,  0, 32'h0,        32'h0,        1, 8'd1);
    vecs[16] = mk(0, 8'h81, 32'h80,       1, 7, 0,  1, 32'h0,        32'h0,        1, 8'd2);
    vecs[17] = mk(0, 8'h00, 32'h0,        1, 7, 0,  1, 32'h0,        32'h0,        0, 8'd2);

    for (int i = 0; i < c_NVEC; i++) begin
      step(vecs[i].rst, vecs[i].sel, vecs[i].wd, vecs[i].re, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d.rd_valid", i),  {31'd0, rd_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d.rd_data_a", i), rd_data_a,         vecs[i].ea);
      chk($sformatf("v%0d.rd_data_b", i), rd_data_b,         vecs[i].eb);
      chk($sformatf("v%0d.sel_err", i),   {31'd0, sel_err},  {31'd0, vecs[i].ee});
      chk($sformatf("v%0d.err_cnt", i),   {24'd0, err_cnt},  {24'd0, vecs[i].ec});
    end

    // Saturation: 300 consecutive multi-hot strobes; counter stops at 0xFF.
    step(1'b1, 8'h00, 32'h0, 1'b0, 3'd0, 3'd0);
    for (int k = 1; k <= 300; k++) begin
      step(1'b0, 8'h03 << (k % 7), 32'hFFFF_FFFF, 1'b0, 3'd0, 3'd0);
      chk($sformatf("sat%0d.sel_err", k), {31'd0, sel_err}, 32'd1);
      chk($sformatf("sat%0d.err_cnt", k), {24'd0, err_cnt}, (k > 255) ? 32'd255 : 32'(k));
    end
    step(1'b0, 8'h00, 32'h0, 1'b1, 3'd1, 3'd6);
    chk("sat_end.sel_err",   {31'd0, sel_err}, 32'd0);
    chk("sat_end.err_cnt",   {24'd0, err_cnt}, 32'd255);
    chk("sat_end.rd_data_a", rd_data_a,        32'd0);
    chk("sat_end.rd_data_b", rd_data_b,        32'd0);

    // Fill entries 0..7 (entry 0 write is discarded), then stream reads.
    step(1'b1, 8'h00, 32'h0, 1'b0, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      model[i] = (i == 0) ? 32'h0 : 32'h1111_1111 * i;
      step(1'b0, 8'h01 << i, 32'h1111_1111 * i + ((i == 0) ? 32'hBAD : 32'h0), 1'b0, 3'd0, 3'd0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 32'h0, 1'b1, 3'(i), 3'(7 - i));
      chk($sformatf("b2b%0d.rd_valid", i),  {31'd0, rd_valid}, 32'd1);
      chk($sformatf("b2b%0d.rd_data_a", i), rd_data_a,         model[i]);
      chk($sformatf("b2b%0d.rd_data_b", i), rd_data_b,         model[7 - i]);
    end
    step(1'b0, 8'h00, 32'h0, 1'b0, 3'd2, 3'd2);
    chk("b2b_end.rd_valid",  {31'd0, rd_valid}, 32'd0);
    chk("b2b_end.rd_data_a", rd_data_a,         model[7]);
    chk("b2b_end.err_cnt",   {24'd0, err_cnt},  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
